clock_set_ctrl: RTL and testbench

- Sequencing controller for the clock block's seconds, minutes and hours counters.
- Generates the 1 Hz advance tick while running.
- Runs a button-driven time-set mode: the user edits hours, minutes and seconds in turn.
- On exit, loads the edited time into the counters with a single load strobe.
- Sits between the debounced front-panel buttons and the counter chain; also drives the display blink enable.

---
 rtl/clock_set_ctrl.sv | 146 ++++++++++++++
 tb/tb_clock_set_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Clock-block sequencer: 1 Hz tick in RUN, button-driven H/M/S time-set mode, single load strobe on exit.
// Optional auto-repeat on a held inc_btn is enabled by defining CLOCK_SET_AUTOREPEAT_EN.
module clock_set_ctrl #(
    parameter int CLK_HZ        = 50_000_000,
    parameter int REPEAT_START  = CLK_HZ / 2,
    parameter int REPEAT_PERIOD = CLK_HZ / 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic       sec_tick,
    output logic       load,
    output logic [4:0] load_hour,
    output logic [5:0] load_min,
    output logic [5:0] load_sec,
    output logic [1:0] mode,
    output logic       blink
);
    typedef enum logic [1:0] {RUN = 2'd0, SET_H = 2'd1, SET_M = 2'd2, SET_S = 2'd3} state_t;

    localparam int PS_W      = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam int BLINK_DIV = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
    localparam int BL_W      = $clog2(BLINK_DIV + 1);
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLK_HZ - 1);
    localparam logic [BL_W-1:0] BL_MAX = BL_W'(BLINK_DIV - 1);

    if (CLK_HZ < 2 || REPEAT_START < 1 || REPEAT_PERIOD < 1) begin : g_param_chk
        $error("clock_set_ctrl: CLK_HZ must be >= 2 and repeat timings >= 1");
    end

    state_t          state, state_nxt;
    logic            mode_prev, inc_prev;
    logic            mode_edge, inc_edge, inc_evt;
    logic [PS_W-1:0] ps_cnt;
    logic [BL_W-1:0] bl_cnt;

    assign mode_edge = mode_btn & ~mode_prev;
    assign inc_edge  = inc_btn & ~inc_prev;
    assign mode      = state;
    assign sec_tick  = (state == RUN) && (ps_cnt == PS_MAX);

    // Previous values start at 1 so a button held across reset release is not an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_prev <= 1'b1;
            inc_prev  <= 1'b1;
        end else begin
            mode_prev <= mode_btn;
            inc_prev  <= inc_btn;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (mode_edge) begin
            case (state)
                RUN:     state_nxt = SET_H;
                SET_H:   state_nxt = SET_M;
                SET_M:   state_nxt = SET_S;
                default: state_nxt = RUN;
            endcase
        end
    end

`ifdef CLOCK_SET_AUTOREPEAT_EN
    localparam int RP_W = $clog2(REPEAT_START + 1);
    localparam logic [RP_W-1:0] RP_START  = RP_W'(REPEAT_START);
    localparam logic [RP_W-1:0] RP_RELOAD =
        (REPEAT_PERIOD > REPEAT_START) ? '0 : RP_W'(REPEAT_START - REPEAT_PERIOD + 1);

    logic [RP_W-1:0] rpt_cnt;
    logic            rpt_fire;

    // Counts held cycles after the press edge; a fire reloads so the next one is REPEAT_PERIOD later.
    assign rpt_fire = inc_btn && inc_prev && (state != RUN) && (rpt_cnt == RP_START);
    assign inc_evt  = inc_edge | rpt_fire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                            rpt_cnt <= '0;
        else if (mode_edge || state == RUN || !inc_btn || inc_edge) rpt_cnt <= '0;
        else if (rpt_fire)                                    rpt_cnt <= RP_RELOAD;
        else                                                  rpt_cnt <= rpt_cnt + 1'b1;
    end
`else
    assign inc_evt = inc_edge;
`endif

    // Mode edge has priority: an inc arriving in the same cycle is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_hour <= '0;
            load_min  <= '0;
            load_sec  <= '0;
        end else if (mode_edge) begin
            if (state == RUN) begin
                load_hour <= cur_hour;
                load_min  <= cur_min;
                load_sec  <= cur_sec;
            end
        end else if (inc_evt) begin
            case (state)
                SET_H:   load_hour <= (load_hour == 5'd23) ? 5'd0 : load_hour + 5'd1;
                SET_M:   load_min  <= (load_min == 6'd59) ? 6'd0 : load_min + 6'd1;
                SET_S:   load_sec  <= 6'd0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) load <= 1'b0;
        else       load <= mode_edge && (state == SET_S);
    end

    // Held at 0 outside RUN so the first tick after a load lands a full second later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                ps_cnt <= '0;
        else if (state != RUN)    ps_cnt <= '0;
        else if (ps_cnt == PS_MAX) ps_cnt <= '0;
        else                      ps_cnt <= ps_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bl_cnt <= '0;
            blink  <= 1'b0;
        end else if (state == RUN || mode_edge) begin
            bl_cnt <= '0;
            blink  <= 1'b0;
        end else if (bl_cnt == BL_MAX) begin
            bl_cnt <= '0;
            blink  <= ~blink;
        end else begin
            bl_cnt <= bl_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboarded bench for clock_set_ctrl at CLK_HZ=8; load strobes are checked against queued expectations.
module tb_clock_set_ctrl;
    localparam int CLK_HZ = 8;
`ifdef CLOCK_SET_AUTOREPEAT_EN
    localparam int EXP_RPT = 3;
`else
    localparam int EXP_RPT = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mode_btn = 1'b0, inc_btn = 1'b0;
    logic [4:0] cur_hour;
    logic [5:0] cur_min, cur_sec;
    logic       sec_tick, load, blink;
    logic [4:0] load_hour;
    logic [5:0] load_min, load_sec;
    logic [1:0] mode;

    int checks = 0;
    int failures = 0;

    typedef struct {int h; int m; int s;} ld_t;
    ld_t sb[$];

    clock_set_ctrl #(.CLK_HZ(CLK_HZ), .REPEAT_START(8), .REPEAT_PERIOD(2)) dut (
        .clk(clk), .reset(reset), .mode_btn(mode_btn), .inc_btn(inc_btn),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .sec_tick(sec_tick), .load(load), .load_hour(load_hour), .load_min(load_min),
        .load_sec(load_sec), .mode(mode), .blink(blink)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One-cycle button pulse preceded by one idle cycle; returns at the negedge after the sampling posedge.
    task automatic pulse(input logic m, input logic i);
        @(negedge clk);
        mode_btn = m;
        inc_btn  = i;
        @(negedge clk);
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
    endtask

    always @(negedge clk) begin : mon
        ld_t e;
        if (!reset && load) begin
            if (sb.size() == 0) chk("load_spurious", 1, 0);
            else begin
                e = sb.pop_front();
                chk("load_hour_sb", load_hour, e.h);
                chk("load_min_sb", load_min, e.m);
                chk("load_sec_sb", load_sec, e.s);
                chk("load_mode_sb", mode, 0);
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        cur_hour = 5'd23; cur_min = 6'd59; cur_sec = 6'd30;
        repeat (2) @(negedge clk);
        chk("rst_mode", mode, 0);
        chk("rst_tick", sec_tick, 0);
        chk("rst_load", load, 0);
        chk("rst_blink", blink, 0);
        chk("rst_lh", load_hour, 0);
        chk("rst_lm", load_min, 0);
        chk("rst_ls", load_sec, 0);

        reset = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            chk("run_tick", sec_tick, (c % CLK_HZ == 0) ? 1 : 0);
            chk("run_quiet", load | blink, 0);
            if (c < 40) @(negedge clk);
        end

        pulse(1'b1, 1'b0);
        chk("cap_mode", mode, 1);
        chk("cap_lh", load_hour, 23);
        chk("cap_lm", load_min, 59);
        chk("cap_ls", load_sec, 30);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("set_no_tick", sec_tick, 0);
        end

        pulse(1'b0, 1'b1);
        chk("hour_wrap", load_hour, 0);
        chk("hour_mode", mode, 1);

        pulse(1'b1, 1'b1);
        chk("simul_mode", mode, 2);
        chk("simul_lh", load_hour, 0);

        pulse(1'b0, 1'b1);
        chk("min_wrap", load_min, 0);

        pulse(1'b1, 1'b0);
        chk("sets_mode", mode, 3);
        chk("blink_k0", blink, 0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("blink_k", blink, (k == 2 || k == 3) ? 1 : 0);
        end

        pulse(1'b0, 1'b1);
        chk("sec_zero", load_sec, 0);
        pulse(1'b0, 1'b1);
        chk("sec_rezero", load_sec, 0);
        chk("sec_keep_lh", load_hour, 0);
        chk("sec_keep_lm", load_min, 0);

        sb.push_back('{0, 0, 0});
        pulse(1'b1, 1'b0);
        chk("exit_mode", mode, 0);
        chk("exit_load", load, 1);
        chk("exit_blink", blink, 0);
        n = 0;
        while (!sec_tick && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("first_tick_lat", n, CLK_HZ - 1);

        // Pending edits abandoned by an asynchronous reset, buttons held across release.
        cur_hour = 5'd10; cur_min = 6'd20; cur_sec = 6'd30;
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        chk("edit_lh", load_hour, 11);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        chk("edit_lm", load_min, 21);
        chk("edit_mode", mode, 2);
        @(negedge clk);
        #2;
        reset = 1'b1; mode_btn = 1'b1; inc_btn = 1'b1;
        #1;
        chk("async_mode", mode, 0);
        chk("async_load", load, 0);
        chk("async_lh", load_hour, 0);
        chk("async_lm", load_min, 0);
        chk("async_ls", load_sec, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("held_no_edge", mode, 0);
        end
        mode_btn = 1'b0; inc_btn = 1'b0;
        repeat (2) @(negedge clk);
        chk("release_mode", mode, 0);

        cur_hour = 5'd5; cur_min = 6'd0; cur_sec = 6'd0;
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        chk("rpt_pre_mode", mode, 2);
        chk("rpt_pre_lm", load_min, 0);
        @(negedge clk);
        inc_btn = 1'b1;
        repeat (13) @(negedge clk);
        inc_btn = 1'b0;
        chk("rpt_lm", load_min, EXP_RPT);
        pulse(1'b1, 1'b0);
        sb.push_back('{5, EXP_RPT, 0});
        pulse(1'b1, 1'b0);
        chk("rpt_exit_mode", mode, 0);

        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
